// File: rtl/spi_reg_peripheral_if.sv
// spi_reg_peripheral_if: SPI pins in, control-register outputs and write strobe out
interface spi_reg_peripheral_if;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       wr_pulse;
  modport master (
    output sclk, copi, ncs,
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, wr_pulse
  );
  modport slave (
    input  sclk, copi, ncs,
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, wr_pulse
  );
endinterface

// File: rtl/spi_reg_peripheral.sv
// spi_reg_peripheral: write-only SPI mode-0 slave committing 16-bit frames into five 8-bit registers
module spi_reg_peripheral #(
  parameter int NUM_REGS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input logic                 clk,
  input logic                 rst,
  spi_reg_peripheral_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t                 r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_copi_s, r_ncs_s;
  logic                   r_sclk_h, r_copi_h, r_ncs_h;
  logic                   r_sclk_rise, r_ncs_fall, r_ncs_rise;
  logic [15:0]            r_sr, w_sr_nxt;
  logic [4:0]             r_cnt, w_cnt_nxt;
  logic [7:0]             r_regs [5];
  logic                   r_wr_pulse;
  logic                   w_sclk, w_copi, w_ncs, w_shift, w_wr;
  assign w_sclk = r_sclk_s[SYNC_STAGES-1];
  assign w_copi = r_copi_s[SYNC_STAGES-1];
  assign w_ncs  = r_ncs_s[SYNC_STAGES-1];
  // Edge flags are registered; the history copy of COPI stays aligned with the SCLK flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s    <= '0;
      r_copi_s    <= '0;
      r_ncs_s     <= '1;
      r_sclk_h    <= 1'b0;
      r_copi_h    <= 1'b0;
      r_ncs_h     <= 1'b1;
      r_sclk_rise <= 1'b0;
      r_ncs_fall  <= 1'b0;
      r_ncs_rise  <= 1'b0;
    end else begin
      r_sclk_s    <= {r_sclk_s[SYNC_STAGES-2:0], bus.sclk};
      r_copi_s    <= {r_copi_s[SYNC_STAGES-2:0], bus.copi};
      r_ncs_s     <= {r_ncs_s[SYNC_STAGES-2:0], bus.ncs};
      r_sclk_h    <= w_sclk;
      r_copi_h    <= w_copi;
      r_ncs_h     <= w_ncs;
      r_sclk_rise <= w_sclk & ~r_sclk_h;
      r_ncs_fall  <= ~w_ncs & r_ncs_h;
      r_ncs_rise  <= w_ncs & ~r_ncs_h;
    end
  end
  // A bit arriving together with the nCS rise is folded in before the commit check
  always_comb begin
    w_shift     = (r_state == SHIFT) && r_sclk_rise;
    w_sr_nxt    = w_shift ? {r_sr[14:0], r_copi_h} : r_sr;
    w_cnt_nxt   = (w_shift && r_cnt != 5'd17) ? r_cnt + 5'd1 : r_cnt;
    w_wr        = (r_state == SHIFT) && r_ncs_rise && w_cnt_nxt == 5'd16 && w_sr_nxt[15] &&
                  w_sr_nxt[14:8] < 7'(NUM_REGS);
    w_state_nxt = r_state == IDLE  ? (r_ncs_fall ? SHIFT : IDLE) :
                  r_state == SHIFT ? (r_ncs_rise ? COMMIT : SHIFT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_sr       <= '0;
      r_cnt      <= '0;
      r_wr_pulse <= 1'b0;
      for (int i = 0; i < 5; i++) r_regs[i] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sr       <= (r_state == IDLE && r_ncs_fall) ? '0 : w_sr_nxt;
      r_cnt      <= (r_state == IDLE && r_ncs_fall) ? '0 : w_cnt_nxt;
      r_wr_pulse <= w_wr;
      for (int i = 0; i < 5; i++)
        if (w_wr && w_sr_nxt[14:8] == 7'(i)) r_regs[i] <= w_sr_nxt[7:0];
    end
  end
  assign bus.en_reg_out_7_0  = r_regs[0];
  assign bus.en_reg_out_15_8 = r_regs[1];
  assign bus.en_reg_pwm_7_0  = r_regs[2];
  assign bus.en_reg_pwm_15_8 = r_regs[3];
  assign bus.pwm_duty_cycle  = r_regs[4];
  assign bus.wr_pulse        = r_wr_pulse;
endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb_spi_reg_peripheral: directed frames against hand-computed register contents and strobe timing
module tb_spi_reg_peripheral;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   npulse = 0;
  int   lat;
  int   p0;
  logic [7:0]  m [5];
  logic [39:0] w_all;
  logic [15:0] frames [5];
  spi_reg_peripheral_if bus ();
  spi_reg_peripheral #(.NUM_REGS(5), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.wr_pulse === 1'b1) npulse++;
  assign w_all = {bus.en_reg_out_7_0, bus.en_reg_out_15_8, bus.en_reg_pwm_7_0,
                  bus.en_reg_pwm_15_8, bus.pwm_duty_cycle};
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [39:0] model();
    return {m[0], m[1], m[2], m[3], m[4]};
  endfunction
  task automatic sclk_pulse(input logic b);
    bus.copi = b;
    step(5);
    bus.sclk = 1'b1;
    step(5);
    bus.sclk = 1'b0;
  endtask
  task automatic send(input logic [16:0] bits, input int n, output int l);
    bus.ncs = 1'b0;
    step(6);
    for (int i = n - 1; i >= 0; i--) sclk_pulse(bits[i]);
    step(5);
    bus.ncs = 1'b1;
    l = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (bus.wr_pulse === 1'b1 && l == 0) l = i;
    end
  endtask
  initial begin
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    for (int i = 0; i < 5; i++) m[i] = 8'h00;
    frames = '{16'h80F0, 16'h81CC, 16'h82AA, 16'h8355, 16'h8480};
    step(1);
    for (int i = 0; i < 5; i++) begin
      bus.sclk = 1'($urandom);
      bus.copi = 1'($urandom);
      bus.ncs  = 1'($urandom);
      step(1);
    end
    chk("reset_regs", w_all, 40'h0);
    chk("reset_pulse", 40'(npulse), 40'd0);
    bus.sclk = 1'b0;
    bus.copi = 1'b0;
    bus.ncs  = 1'b1;
    step(1);
    rst = 1'b0;
    step(6);
    chk("post_reset_regs", w_all, 40'h0);
    chk("post_reset_pulse", 40'(npulse), 40'd0);
    for (int f = 0; f < 5; f++) begin
      p0 = npulse;
      send({1'b0, frames[f]}, 16, lat);
      m[frames[f][10:8]] = frames[f][7:0];
      chk($sformatf("write%0d_regs", f), w_all, model());
      chk($sformatf("write%0d_latency", f), 40'(lat), 40'd4);
      chk($sformatf("write%0d_pulses", f), 40'(npulse - p0), 40'd1);
    end
    chk("writes_total", w_all, 40'hF0CCAA5580);
    p0 = npulse;
    send({1'b0, 16'h04FF}, 16, lat);
    chk("read_frame_regs", w_all, model());
    send({1'b0, 16'h85FF}, 16, lat);
    chk("addr5_regs", w_all, model());
    send({1'b0, 16'hFF12}, 16, lat);
    chk("addr7f_regs", w_all, model());
    chk("invalid_pulses", 40'(npulse - p0), 40'd0);
    p0 = npulse;
    send({2'b0, 15'h4219}, 15, lat);
    chk("short_frame_regs", w_all, model());
    send({16'h8433, 1'b1}, 17, lat);
    chk("long_frame_regs", w_all, model());
    chk("length_err_pulses", 40'(npulse - p0), 40'd0);
    p0 = npulse;
    send({1'b0, 16'h8433}, 16, lat);
    m[4] = 8'h33;
    chk("recover_regs", w_all, 40'hF0CCAA5533);
    chk("recover_pulses", 40'(npulse - p0), 40'd1);
    p0 = npulse;
    for (int i = 0; i < 8; i++) sclk_pulse(1'b1);
    step(5);
    chk("spurious_sclk_regs", w_all, model());
    chk("spurious_sclk_pulses", 40'(npulse - p0), 40'd0);
    send({1'b0, 16'h8001}, 16, lat);
    m[0] = 8'h01;
    chk("after_spurious_regs", w_all, 40'h01CCAA5533);
    chk("after_spurious_pulses", 40'(npulse - p0), 40'd1);
    bus.ncs = 1'b0;
    step(6);
    for (int i = 15; i >= 6; i--) sclk_pulse(i == 15 || i == 9 || i < 8);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midframe_reset_regs", w_all, 40'h0);
    p0 = npulse;
    for (int i = 5; i >= 0; i--) sclk_pulse(1'b1);
    step(5);
    bus.ncs = 1'b1;
    step(12);
    chk("midframe_tail_regs", w_all, 40'h0);
    chk("midframe_tail_pulses", 40'(npulse - p0), 40'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
